// File: rtl/power_meter_avg_if.sv
// Bus between the averaging power meter, its host logic and the per-channel ADC drivers.
// Channel 2k carries voltage and channel 2k+1 carries current for pair k.
interface power_meter_avg_if #(
  parameter int unsigned NUM_PAIRS = 2,
  parameter int unsigned ADC_W     = 12
);
  logic                            start;
  logic                            continuous;
  logic [3:0]                      avg_log2;
  logic                            busy;
  logic                            done;
  logic                            timeout_err;
  logic                            adc_start;
  logic [2*NUM_PAIRS-1:0]          adc_busy;
  logic [2*NUM_PAIRS-1:0]          adc_valid;
  logic [2*NUM_PAIRS*ADC_W-1:0]    adc_data;
  logic [NUM_PAIRS*ADC_W-1:0]      data_v;
  logic [NUM_PAIRS*ADC_W-1:0]      data_i;
  logic [NUM_PAIRS*2*ADC_W-1:0]    data_p;

  // Host and ADC-driver side.
  modport master (
    output start, continuous, avg_log2, adc_busy, adc_valid, adc_data,
    input  busy, done, timeout_err, adc_start, data_v, data_i, data_p
  );

  // Meter side.
  modport slave (
    input  start, continuous, avg_log2, adc_busy, adc_valid, adc_data,
    output busy, done, timeout_err, adc_start, data_v, data_i, data_p
  );
endinterface

// File: rtl/power_meter_avg.sv
// Multi-pair V/I meter: averages 2^avg_log2 samples per channel, then forms V*I per pair
// through one shared multiplier and commits all results together with a done pulse.
module power_meter_avg #(
  parameter int unsigned NUM_PAIRS    = 2,
  parameter int unsigned ADC_W        = 12,
  parameter int unsigned MAX_AVG_LOG2 = 6,
  parameter int unsigned ADC_TIMEOUT  = 1023
) (
  input logic               clk,
  input logic               rst,
  power_meter_avg_if.slave  bus
);

  localparam int unsigned NCh   = 2 * NUM_PAIRS;
  localparam int unsigned AccW  = ADC_W + MAX_AVG_LOG2;
  localparam int unsigned AvgW  = $clog2(MAX_AVG_LOG2 + 1);
  localparam int unsigned CntW  = MAX_AVG_LOG2 + 1;
  localparam int unsigned TmoW  = $clog2(ADC_TIMEOUT + 1);
  localparam int unsigned PairW = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;
  localparam logic [3:0]  MaxAvg = 4'(MAX_AVG_LOG2);

  typedef enum logic [2:0] {
    StIdle, StConvert, StSettle, StAccum, StLatch, StMult, StDone
  } state_e;

  state_e                 state_q;
  logic [AvgW-1:0]        avg_q;
  logic [CntW-1:0]        cnt_q;
  logic [TmoW-1:0]        tmo_q;
  logic [PairW-1:0]       idx_q;
  logic [NCh-1:0]         flags_q;
  logic [ADC_W-1:0]       held_q [NCh];
  logic [AccW-1:0]        acc_q  [NCh];
  logic [ADC_W-1:0]       shv_q  [NUM_PAIRS];
  logic [ADC_W-1:0]       shi_q  [NUM_PAIRS];
  logic [2*ADC_W-1:0]     prod_q [NUM_PAIRS];
  logic                   busy_q, done_q, timeout_err_q, adc_start_q;
  logic [NUM_PAIRS*ADC_W-1:0]   data_v_q, data_i_q;
  logic [NUM_PAIRS*2*ADC_W-1:0] data_p_q;

  logic [AvgW-1:0]    avg_clamped;
  logic [CntW-1:0]    cnt_nxt, cnt_tgt;
  logic               all_cap, tmo_hit, adc_idle;
  logic [ADC_W-1:0]   avg_ch [NCh];
  logic [2*ADC_W-1:0] mul_out;

  assign avg_clamped = (bus.avg_log2 > MaxAvg) ? AvgW'(MAX_AVG_LOG2) : bus.avg_log2[AvgW-1:0];
  assign cnt_nxt     = cnt_q + 1'b1;
  assign cnt_tgt     = CntW'(1) << avg_q;
  // A valid arriving this cycle counts toward completion, so no cycle is lost per sample.
  assign all_cap     = &(flags_q | bus.adc_valid);
  assign tmo_hit     = (tmo_q == TmoW'(ADC_TIMEOUT - 1));
  assign adc_idle    = (bus.adc_busy == '0);
  assign mul_out     = {{ADC_W{1'b0}}, shv_q[idx_q]} * {{ADC_W{1'b0}}, shi_q[idx_q]};

  always_comb begin
    for (int c = 0; c < NCh; c++) begin
      avg_ch[c] = ADC_W'(acc_q[c] >> avg_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      avg_q         <= '0;
      cnt_q         <= '0;
      tmo_q         <= '0;
      idx_q         <= '0;
      flags_q       <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      adc_start_q   <= 1'b0;
      data_v_q      <= '0;
      data_i_q      <= '0;
      data_p_q      <= '0;
      for (int c = 0; c < NCh; c++) begin
        held_q[c] <= '0;
        acc_q[c]  <= '0;
      end
      for (int k = 0; k < NUM_PAIRS; k++) begin
        shv_q[k]  <= '0;
        shi_q[k]  <= '0;
        prod_q[k] <= '0;
      end
    end else begin
      adc_start_q <= 1'b0;
      done_q      <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            avg_q         <= avg_clamped;
            timeout_err_q <= 1'b0;
            cnt_q         <= '0;
            tmo_q         <= '0;
            flags_q       <= '0;
            for (int c = 0; c < NCh; c++) acc_q[c] <= '0;
            adc_start_q   <= 1'b1;
            busy_q        <= 1'b1;
            state_q       <= StConvert;
          end
        end
        StConvert: begin
          tmo_q <= tmo_q + 1'b1;
          for (int c = 0; c < NCh; c++) begin
            if (bus.adc_valid[c] && !flags_q[c]) begin
              held_q[c]  <= bus.adc_data[c*ADC_W +: ADC_W];
              flags_q[c] <= 1'b1;
            end
          end
          // SETTLE is skipped when the drivers are already quiet.
          if (all_cap) begin
            state_q <= adc_idle ? StAccum : StSettle;
          end else if (tmo_hit) begin
            timeout_err_q <= 1'b1;
            flags_q       <= '0;
            busy_q        <= 1'b0;
            state_q       <= StIdle;
          end
        end
        StSettle: begin
          tmo_q <= tmo_q + 1'b1;
          if (adc_idle) begin
            state_q <= StAccum;
          end else if (tmo_hit) begin
            timeout_err_q <= 1'b1;
            flags_q       <= '0;
            busy_q        <= 1'b0;
            state_q       <= StIdle;
          end
        end
        StAccum: begin
          for (int c = 0; c < NCh; c++) acc_q[c] <= acc_q[c] + AccW'(held_q[c]);
          flags_q <= '0;
          cnt_q   <= cnt_nxt;
          if (cnt_nxt == cnt_tgt) begin
            state_q <= StLatch;
          end else begin
            tmo_q       <= '0;
            adc_start_q <= 1'b1;
            state_q     <= StConvert;
          end
        end
        StLatch: begin
          for (int k = 0; k < NUM_PAIRS; k++) begin
            shv_q[k] <= avg_ch[2*k];
            shi_q[k] <= avg_ch[2*k+1];
          end
          idx_q   <= '0;
          state_q <= StMult;
        end
        StMult: begin
          prod_q[idx_q] <= mul_out;
          idx_q         <= idx_q + 1'b1;
          // The last product bypasses prod_q so every output lands in the same cycle.
          if (idx_q == PairW'(NUM_PAIRS - 1)) begin
            for (int k = 0; k < NUM_PAIRS; k++) begin
              data_v_q[k*ADC_W +: ADC_W]     <= shv_q[k];
              data_i_q[k*ADC_W +: ADC_W]     <= shi_q[k];
              data_p_q[k*2*ADC_W +: 2*ADC_W] <= (PairW'(k) == idx_q) ? mul_out : prod_q[k];
            end
            done_q  <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          if (bus.continuous) begin
            cnt_q       <= '0;
            tmo_q       <= '0;
            flags_q     <= '0;
            for (int c = 0; c < NCh; c++) acc_q[c] <= '0;
            adc_start_q <= 1'b1;
            state_q     <= StConvert;
          end else begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.timeout_err = timeout_err_q;
  assign bus.adc_start   = adc_start_q;
  assign bus.data_v      = data_v_q;
  assign bus.data_i      = data_i_q;
  assign bus.data_p      = data_p_q;

endmodule

// File: tb/tb_power_meter_avg.sv
// Directed bench for power_meter_avg with a fixed-latency ADC model (T cycles per conversion).
module tb_power_meter_avg;
  localparam int T = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  power_meter_avg_if #(.NUM_PAIRS(2), .ADC_W(12)) bus ();

  power_meter_avg #(
    .NUM_PAIRS(2), .ADC_W(12), .MAX_AVG_LOG2(6), .ADC_TIMEOUT(1023)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, starts = 0, base = 0, dones = 0, dbase = 0;
  int first_start_cyc = 0, last_start_cyc = 0, last_done_cyc = 0, prev_done_cyc = 0;
  int tmo_cyc = 0;
  bit mode_ramp = 1'b0, drop_ch3 = 1'b0;
  logic [11:0] dq[$];

  function automatic logic [11:0] const_val(input int c);
    case (c)
      0:       return 12'd500;
      1:       return 12'd100;
      default: return 12'd4095;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [3:0] a);
    @(negedge clk);
    base          = starts;
    dbase         = dones;
    bus.start     = 1'b1;
    bus.avg_log2  = a;
    @(negedge clk);
    bus.start     = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int i = 0;
    while (bus.busy && i < max) begin
      @(negedge clk);
      i++;
    end
    check("idle_reached", {63'd0, bus.busy}, 64'd0);
    @(negedge clk);
  endtask

  task automatic wait_done_pulse(input int max);
    int i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (!bus.done && i < max);
    check("done_seen", {63'd0, bus.done}, 64'd1);
  endtask

  // ADC drivers: valid T cycles after adc_start, busy low in that same cycle.
  initial begin
    int k;
    int cur_s;
    bit act;
    bit tmo_prev;
    k = 0; cur_s = 0; act = 1'b0; tmo_prev = 1'b0;
    bus.adc_busy  = '0;
    bus.adc_valid = '0;
    bus.adc_data  = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.adc_start) begin
        cur_s = starts - base;
        if (cur_s == 0) first_start_cyc = cyc;
        last_start_cyc = cyc;
        starts++;
        k   = 0;
        act = 1'b1;
      end else if (act) begin
        k++;
      end
      bus.adc_busy = {4{act && (k < T)}};
      if (act && k == T) begin
        for (int c = 0; c < 4; c++)
          bus.adc_data[c*12 +: 12] = mode_ramp ? 12'(cur_s) : const_val(c);
        bus.adc_valid = (drop_ch3 && cur_s == 2) ? 4'b0111 : 4'b1111;
        act = 1'b0;
      end else begin
        bus.adc_valid = '0;
      end
      if (bus.done) begin
        dones++;
        prev_done_cyc = last_done_cyc;
        last_done_cyc = cyc;
        dq.push_back(bus.data_v[11:0]);
      end
      if (bus.timeout_err && !tmo_prev) tmo_cyc = cyc;
      tmo_prev = bus.timeout_err;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int qb;
    bus.start      = 1'b0;
    bus.continuous = 1'b0;
    bus.avg_log2   = 4'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy",  {63'd0, bus.busy},        64'd0);
    check("rst_done",  {63'd0, bus.done},        64'd0);
    check("rst_terr",  {63'd0, bus.timeout_err}, 64'd0);
    check("rst_start", {63'd0, bus.adc_start},   64'd0);
    check("rst_dv",    {40'd0, bus.data_v},      64'd0);
    check("rst_dp",    {16'd0, bus.data_p},      64'd0);

    // Constant samples, 8-deep average.
    mode_ramp = 1'b0;
    do_start(4'd3);
    wait_idle(2000);
    check("c_starts", 64'(starts - base), 64'd8);
    check("c_dones",  64'(dones - dbase), 64'd1);
    check("c_dv",     {40'd0, bus.data_v}, {40'd0, 12'd4095, 12'd500});
    check("c_di",     {40'd0, bus.data_i}, {40'd0, 12'd4095, 12'd100});
    check("c_dp",     {16'd0, bus.data_p}, {16'd0, 24'd16769025, 24'd50000});
    check("c_lat",    64'(last_done_cyc - first_start_cyc + 1), 64'd148);
    check("c_terr",   {63'd0, bus.timeout_err}, 64'd0);

    // Ramp 0..7: 28 >> 3 = 3.
    mode_ramp = 1'b1;
    do_start(4'd3);
    wait_idle(2000);
    check("r_dv", {40'd0, bus.data_v}, {40'd0, 12'd3, 12'd3});
    check("r_di", {40'd0, bus.data_i}, {40'd0, 12'd3, 12'd3});
    check("r_dp", {16'd0, bus.data_p}, {16'd0, 24'd9, 24'd9});

    // Single sample.
    mode_ramp = 1'b0;
    do_start(4'd0);
    wait_idle(200);
    check("a0_starts", 64'(starts - base), 64'd1);
    check("a0_dv",     {40'd0, bus.data_v}, {40'd0, 12'd4095, 12'd500});
    check("a0_dp",     {16'd0, bus.data_p}, {16'd0, 24'd16769025, 24'd50000});
    check("a0_lat",    64'(last_done_cyc - first_start_cyc + 1), 64'd22);

    // avg_log2=9 clamps to 6; ramp 0..63 sums to 2016, >> 6 = 31.
    mode_ramp = 1'b1;
    do_start(4'd9);
    wait_idle(3000);
    check("a9_starts", 64'(starts - base), 64'd64);
    check("a9_dv",     {40'd0, bus.data_v}, {40'd0, 12'd31, 12'd31});
    check("a9_dp",     {16'd0, bus.data_p}, {16'd0, 24'd961, 24'd961});

    // Channel 3 silent on sample 2 -> timeout.
    mode_ramp = 1'b0;
    drop_ch3  = 1'b1;
    do_start(4'd3);
    wait_idle(2000);
    drop_ch3  = 1'b0;
    check("to_terr",   {63'd0, bus.timeout_err}, 64'd1);
    check("to_busy",   {63'd0, bus.busy},        64'd0);
    check("to_starts", 64'(starts - base),       64'd3);
    check("to_dones",  64'(dones - dbase),       64'd0);
    check("to_time",   64'(tmo_cyc - last_start_cyc), 64'd1023);
    check("to_dv",     {40'd0, bus.data_v}, {40'd0, 12'd31, 12'd31});
    check("to_dp",     {16'd0, bus.data_p}, {16'd0, 24'd961, 24'd961});
    do_start(4'd0);
    check("to_clr",    {63'd0, bus.timeout_err}, 64'd0);
    check("to_rbusy",  {63'd0, bus.busy},        64'd1);
    wait_idle(200);
    check("to_rdv",    {40'd0, bus.data_v}, {40'd0, 12'd4095, 12'd500});

    // Continuous, 2-deep ramp: measurement m averages 2m and 2m+1 -> 2m.
    mode_ramp      = 1'b1;
    bus.continuous = 1'b1;
    qb = dq.size();
    do_start(4'd1);
    wait_done_pulse(200);
    bus.start    = 1'b1;   // start in DONE must be ignored
    bus.avg_log2 = 4'd0;
    @(negedge clk);
    bus.start    = 1'b0;
    wait_done_pulse(200);
    repeat (7) @(negedge clk);
    bus.start    = 1'b1;   // start mid-CONVERT must be ignored
    @(negedge clk);
    bus.start    = 1'b0;
    wait_done_pulse(200);
    repeat (5) @(negedge clk);
    bus.continuous = 1'b0;
    wait_idle(200);
    check("ct_dones",  64'(dones - dbase),  64'd4);
    check("ct_starts", 64'(starts - base),  64'd8);
    check("ct_v1",     {52'd0, dq[qb+1]},   64'd2);
    check("ct_v2",     {52'd0, dq[qb+2]},   64'd4);
    check("ct_v3",     {52'd0, dq[qb+3]},   64'd6);
    check("ct_dp",     {16'd0, bus.data_p}, {16'd0, 24'd36, 24'd36});
    check("ct_period", 64'(last_done_cyc - prev_done_cyc), 64'd40);
    repeat (50) @(negedge clk);
    check("ct_halt",   64'(dones - dbase),  64'd4);

    // Reset mid-CONVERT, then a clean measurement.
    mode_ramp = 1'b0;
    do_start(4'd3);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mr_busy",  {63'd0, bus.busy},      64'd0);
    check("mr_done",  {63'd0, bus.done},      64'd0);
    check("mr_start", {63'd0, bus.adc_start}, 64'd0);
    check("mr_dv",    {40'd0, bus.data_v},    64'd0);
    check("mr_di",    {40'd0, bus.data_i},    64'd0);
    check("mr_dp",    {16'd0, bus.data_p},    64'd0);
    rst = 1'b0;
    do_start(4'd0);
    wait_idle(200);
    check("mr_dones", 64'(dones - dbase),  64'd1);
    check("mr_rdv",   {40'd0, bus.data_v}, {40'd0, 12'd4095, 12'd500});
    check("mr_rdp",   {16'd0, bus.data_p}, {16'd0, 24'd16769025, 24'd50000});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
